// File: rtl/pc_stack_seq.sv
// rtl/pc_stack_seq.sv - program counter with hardware return-address stack
module pc_stack_seq #(
   parameter int ADDR_W      = 6,
   parameter int STACK_DEPTH = 4,
   localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              clear_pc,
   input  logic              ret,
   input  logic              call,
   input  logic              load_pc,
   input  logic              branch_c,
   input  logic              carry,
   input  logic              enable_pc,
   input  logic [ADDR_W-1:0] adr_in,
   output logic [ADDR_W-1:0] adr_out,
   output logic [SP_W-1:0]   sp_level,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_fault
);

   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] stack_top;
   logic [ADDR_W-1:0] next_pc;
   logic [SP_W-1:0]   next_sp;
   logic              next_fault;
   logic              do_push;

   assign pc_inc      = adr_out + ADDR_W'(1);
   assign stack_full  = (sp_level == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp_level == '0);

   // Entry just below the occupancy count is the most recent return address.
   always_comb begin
      stack_top = stack_mem[0];
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (sp_level == SP_W'(i + 1)) stack_top = stack_mem[i];
      end
   end

   always_comb begin
      next_pc    = adr_out;
      next_sp    = sp_level;
      next_fault = stack_fault;
      do_push    = 1'b0;
      if (clear_pc) begin
         next_pc    = '0;
         next_sp    = '0;
         next_fault = 1'b0;
      end else if (ret) begin
         if (stack_empty) begin
            next_fault = 1'b1;
         end else begin
            next_pc = stack_top;
            next_sp = sp_level - SP_W'(1);
         end
      end else if (call) begin
         if (stack_full) begin
            next_fault = 1'b1;
         end else begin
            do_push = 1'b1;
            next_pc = adr_in;
            next_sp = sp_level + SP_W'(1);
         end
      end else if (load_pc) begin
         next_pc = adr_in;
      end else if (branch_c) begin
         next_pc = carry ? adr_in : pc_inc;
      end else if (enable_pc) begin
         next_pc = pc_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adr_out     <= '0;
         sp_level    <= '0;
         stack_fault <= 1'b0;
      end else if (ce) begin
         adr_out     <= next_pc;
         sp_level    <= next_sp;
         stack_fault <= next_fault;
      end
   end

   // Entry storage needs no reset: slots at or above sp_level are never read.
   always_ff @(posedge clk) begin
      if (ce && do_push) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_level == SP_W'(i)) stack_mem[i] <= pc_inc;
         end
      end
   end

endmodule

// File: tb/tb_pc_stack_seq.sv
// tb/tb_pc_stack_seq.sv - scoreboard bench for pc_stack_seq against a queue-based model
module tb_pc_stack_seq;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 4;
   localparam int SP_W   = $clog2(DEPTH + 1);

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_CLR  = 6'b100000;
   localparam logic [5:0] C_RET  = 6'b010000;
   localparam logic [5:0] C_CALL = 6'b001000;
   localparam logic [5:0] C_LD   = 6'b000100;
   localparam logic [5:0] C_BR   = 6'b000010;
   localparam logic [5:0] C_EN   = 6'b000001;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ce = 1'b0;
   logic              clear_pc = 1'b0, ret = 1'b0, call = 1'b0;
   logic              load_pc = 1'b0, branch_c = 1'b0, carry = 1'b0, enable_pc = 1'b0;
   logic [ADDR_W-1:0] adr_in = '0;
   logic [ADDR_W-1:0] adr_out;
   logic [SP_W-1:0]   sp_level;
   logic              stack_full, stack_empty, stack_fault;

   pc_stack_seq #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ce(ce), .clear_pc(clear_pc), .ret(ret), .call(call),
      .load_pc(load_pc), .branch_c(branch_c), .carry(carry), .enable_pc(enable_pc),
      .adr_in(adr_in), .adr_out(adr_out), .sp_level(sp_level),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_fault(stack_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned adr;
      int unsigned sp;
      bit          full;
      bit          empty;
      bit          fault;
      int          step;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          step_no = 0;

   // Reference model: PC as an integer modulo 2**ADDR_W, stack as a plain LIFO queue.
   int unsigned m_pc = 0;
   int unsigned m_stk[$];
   bit          m_fault = 0;

   function automatic int unsigned inc(input int unsigned v);
      return (v + 1) % (1 << ADDR_W);
   endfunction

   task automatic push_expect();
      exp_t e;
      e.adr   = m_pc;
      e.sp    = m_stk.size();
      e.full  = (m_stk.size() == DEPTH);
      e.empty = (m_stk.size() == 0);
      e.fault = m_fault;
      e.step  = step_no;
      exp_q.push_back(e);
      step_no++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      {clear_pc, ret, call, load_pc, branch_c, enable_pc} = C_NONE;
      m_pc = 0;
      m_stk.delete();
      m_fault = 0;
      push_expect();
   endtask

   task automatic apply(input logic c_ce, input logic [5:0] cmd, input logic cy,
                        input logic [ADDR_W-1:0] a);
      @(negedge clk);
      rst = 1'b0;
      ce  = c_ce;
      {clear_pc, ret, call, load_pc, branch_c, enable_pc} = cmd;
      carry  = cy;
      adr_in = a;
      if (c_ce) begin
         if (cmd[5]) begin
            m_pc = 0; m_stk.delete(); m_fault = 0;
         end else if (cmd[4]) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_fault = 1;
         end else if (cmd[3]) begin
            if (m_stk.size() < DEPTH) begin
               m_stk.push_back(inc(m_pc));
               m_pc = int'(a);
            end else m_fault = 1;
         end else if (cmd[2]) begin
            m_pc = int'(a);
         end else if (cmd[1]) begin
            m_pc = cy ? int'(a) : inc(m_pc);
         end else if (cmd[0]) begin
            m_pc = inc(m_pc);
         end
      end
      push_expect();
   endtask

   task automatic check(input string name, input int unsigned got, input int unsigned want,
                        input int stp);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, stp, got, want);
      end
   endtask

   // Monitor: one registered result per clock, compared against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("adr_out",     int'(adr_out),     e.adr,         e.step);
            check("sp_level",    int'(sp_level),    e.sp,          e.step);
            check("stack_full",  int'(stack_full),  int'(e.full),  e.step);
            check("stack_empty", int'(stack_empty), int'(e.empty), e.step);
            check("stack_fault", int'(stack_fault), int'(e.fault), e.step);
         end
      end
   end

   initial begin
      do_reset();
      // T1: reset mid-run with PC=0x2A and two entries
      apply(1, C_CALL, 0, 6'h10);
      apply(1, C_CALL, 0, 6'h2A);
      do_reset();
      // T2: increment wrap
      apply(1, C_LD, 0, 6'h3E);
      repeat (3) apply(1, C_EN, 0, 6'h00);
      // T3: nested call/return
      apply(1, C_LD, 0, 6'h05);
      apply(1, C_CALL, 0, 6'h20);
      apply(1, C_CALL, 0, 6'h30);
      apply(1, C_RET, 0, 6'h00);
      apply(1, C_RET, 0, 6'h00);
      // T4: overflow on the fifth call
      apply(1, C_CLR, 0, 6'h00);
      for (int i = 0; i < 5; i++) apply(1, C_CALL, 0, ADDR_W'(8 + i));
      apply(1, C_LD, 0, 6'h11);
      // T5: underflow then clear
      apply(1, C_CLR, 0, 6'h00);
      apply(1, C_LD, 0, 6'h09);
      apply(1, C_RET, 0, 6'h00);
      apply(1, C_CLR, 0, 6'h00);
      // T6: clock enable, priority, branch on carry
      apply(0, C_CALL, 0, 6'h33);
      apply(1, C_CALL, 0, 6'h15);
      apply(0, C_RET | C_EN, 0, 6'h00);
      apply(1, C_RET | C_CALL | C_EN, 0, 6'h22);
      apply(1, C_LD, 0, 6'h07);
      apply(1, C_BR, 0, 6'h10);
      apply(1, C_LD, 0, 6'h07);
      apply(1, C_BR, 1, 6'h10);
      apply(1, C_LD | C_EN, 0, 6'h3F);
      apply(1, C_CALL, 0, 6'h01);
      apply(1, C_RET, 0, 6'h00);
      // Randomised traffic with occasional clears and resets
      for (int i = 0; i < 400; i++) begin
         logic [5:0] cmd;
         logic       c_ce;
         cmd  = 6'($urandom) & 6'b011111;
         if ($urandom_range(0, 29) == 0) cmd[5] = 1'b1;
         c_ce = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 99) == 0) do_reset();
         else apply(c_ce, cmd, 1'($urandom), ADDR_W'($urandom));
      end
      apply(1, C_NONE, 0, 6'h00);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
